// File: rtl/synchronous_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with a registered head word, programmable
// almost-full/almost-empty flags, a synchronous flush and a sticky high-water mark.
module synchronous_fifo_fwft #(
  parameter int DATA_WIDTH_P    = 32,
  parameter int ADDRESS_WIDTH_P = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       ing_valid,
  output logic                       ing_ready,
  input  logic [DATA_WIDTH_P-1:0]    ing_data,
  output logic                       egr_valid,
  input  logic                       egr_ready,
  output logic [DATA_WIDTH_P-1:0]    egr_data,
  input  logic [ADDRESS_WIDTH_P:0]   cr_almost_full_level,
  input  logic [ADDRESS_WIDTH_P:0]   cr_almost_empty_level,
  output logic [ADDRESS_WIDTH_P:0]   sr_fill_level,
  output logic                       sr_almost_full,
  output logic                       sr_almost_empty,
  output logic [ADDRESS_WIDTH_P:0]   sr_max_fill_level
);

  localparam int                       DEPTH_LP    = 1 << ADDRESS_WIDTH_P;
  localparam logic [ADDRESS_WIDTH_P:0]   FILL_ONE_LP = 1;
  localparam logic [ADDRESS_WIDTH_P-1:0] PTR_ONE_LP  = 1;

  logic [DATA_WIDTH_P-1:0]    mem [DEPTH_LP];
  logic [ADDRESS_WIDTH_P-1:0] wr_ptr;
  logic [ADDRESS_WIDTH_P-1:0] rd_ptr;
  logic                       push;
  logic                       pop;
  logic                       out_free;
  logic                       array_empty;
  logic                       refill;
  logic                       bypass;
  logic                       array_write;
  logic [ADDRESS_WIDTH_P:0]   fill_next;

  // The array never holds more than CAP-1 words because the head lives in egr_data,
  // so pointer equality alone is an unambiguous empty indication.
  assign ing_ready   = !sr_fill_level[ADDRESS_WIDTH_P];
  assign push        = ing_valid && ing_ready;
  assign pop         = egr_valid && egr_ready;
  assign out_free    = !egr_valid || egr_ready;
  assign array_empty = (wr_ptr == rd_ptr);
  assign refill      = out_free && !array_empty;
  assign bypass      = push && out_free && array_empty;
  assign array_write = push && !bypass && !clear;

  always_comb begin
    fill_next = sr_fill_level;
    if (push && !pop)
      fill_next = sr_fill_level + FILL_ONE_LP;
    else if (pop && !push)
      fill_next = sr_fill_level - FILL_ONE_LP;
  end

  always_ff @(posedge clk) begin
    if (array_write)
      mem[wr_ptr] <= ing_data;
  end

  // Flags and high-water mark are registered from the next fill so they always agree
  // with sr_fill_level; clear overrides any concurrent push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      egr_valid         <= 1'b0;
      egr_data          <= '0;
      sr_fill_level     <= '0;
      sr_max_fill_level <= '0;
      sr_almost_full    <= 1'b0;
      sr_almost_empty   <= 1'b1;
    end else if (clear) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      egr_valid         <= 1'b0;
      sr_fill_level     <= '0;
      sr_max_fill_level <= '0;
      sr_almost_full    <= (cr_almost_full_level == '0);
      sr_almost_empty   <= 1'b1;
    end else begin
      if (array_write)
        wr_ptr <= wr_ptr + PTR_ONE_LP;
      if (refill) begin
        egr_data  <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + PTR_ONE_LP;
        egr_valid <= 1'b1;
      end else if (bypass) begin
        egr_data  <= ing_data;
        egr_valid <= 1'b1;
      end else if (out_free) begin
        egr_valid <= 1'b0;
      end
      sr_fill_level   <= fill_next;
      sr_almost_full  <= (fill_next >= cr_almost_full_level);
      sr_almost_empty <= (fill_next <= cr_almost_empty_level);
      if (fill_next > sr_max_fill_level)
        sr_max_fill_level <= fill_next;
    end
  end

endmodule

// File: tb/tb_synchronous_fifo_fwft.sv
// Directed bench for synchronous_fifo_fwft (capacity 4) with a queue-based reference
// model; outputs are sampled on the falling clock edge.
module tb_synchronous_fifo_fwft;

  localparam int AW  = 2;
  localparam int DW  = 32;
  localparam int CAP = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          ing_valid;
  logic          ing_ready;
  logic [DW-1:0] ing_data;
  logic          egr_valid;
  logic          egr_ready;
  logic [DW-1:0] egr_data;
  logic [AW:0]   af_lvl;
  logic [AW:0]   ae_lvl;
  logic [AW:0]   sr_fill_level;
  logic          sr_almost_full;
  logic          sr_almost_empty;
  logic [AW:0]   sr_max_fill_level;

  logic [DW-1:0] q[$];
  int            m_max;
  bit            m_af;
  bit            m_ae;
  int            checks;
  int            errors;

  synchronous_fifo_fwft #(.DATA_WIDTH_P(DW), .ADDRESS_WIDTH_P(AW)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .clear                 (clear),
    .ing_valid             (ing_valid),
    .ing_ready             (ing_ready),
    .ing_data              (ing_data),
    .egr_valid             (egr_valid),
    .egr_ready             (egr_ready),
    .egr_data              (egr_data),
    .cr_almost_full_level  (af_lvl),
    .cr_almost_empty_level (ae_lvl),
    .sr_fill_level         (sr_fill_level),
    .sr_almost_full        (sr_almost_full),
    .sr_almost_empty       (sr_almost_empty),
    .sr_max_fill_level     (sr_max_fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("ing_ready", 32'(ing_ready), 32'(q.size() < CAP));
    check("egr_valid", 32'(egr_valid), 32'(q.size() > 0));
    check("fill", 32'(sr_fill_level), 32'(q.size()));
    check("almost_full", 32'(sr_almost_full), 32'(m_af));
    check("almost_empty", 32'(sr_almost_empty), 32'(m_ae));
    check("max_fill", 32'(sr_max_fill_level), 32'(m_max));
    if (q.size() > 0)
      check("head_data", egr_data, q[0]);
  endtask

  task automatic model_reset();
    q.delete();
    m_max = 0;
    m_af  = 1'b0;
    m_ae  = 1'b1;
  endtask

  // Called just after a falling edge: drive one cycle, update the model at the rising edge.
  task automatic applyStimulus(input logic iv, input logic [DW-1:0] id,
                               input logic er, input logic cl);
    bit do_push;
    bit do_pop;
    int f;
    ing_valid = iv;
    ing_data  = id;
    egr_ready = er;
    clear     = cl;
    do_push   = iv && (q.size() < CAP);
    do_pop    = er && (q.size() > 0);
    @(posedge clk);
    if (cl) begin
      q.delete();
      m_max = 0;
      m_af  = (af_lvl == 0);
      m_ae  = 1'b1;
    end else begin
      if (do_pop)
        check("pop_data", egr_data, q.pop_front());
      if (do_push)
        q.push_back(id);
      f = q.size();
      if (f > m_max) m_max = f;
      m_af = (f >= int'(af_lvl));
      m_ae = (f <= int'(ae_lvl));
    end
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    ing_valid = 1'b0;
    ing_data  = '0;
    egr_ready = 1'b0;
    af_lvl    = 3'(CAP);
    ae_lvl    = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    checkOutput();
    check("reset_egr_data", egr_data, 32'h0);
    rst_n = 1'b1;

    $display("[TB] single word");
    applyStimulus(1'b1, 32'hA5, 1'b0, 1'b0);
    check("single_data", egr_data, 32'hA5);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    check("single_empty", 32'(egr_valid), 32'h0);

    $display("[TB] fill to full");
    for (int i = 1; i <= 4; i++)
      applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
    check("full_ready", 32'(ing_ready), 32'h0);
    applyStimulus(1'b1, 32'd5, 1'b1, 1'b0);
    check("after_full_fill", 32'(sr_fill_level), 32'd3);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] streaming");
    for (int i = 0; i < 100; i++)
      applyStimulus(1'b1, 32'(1000 + i), 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] thresholds");
    af_lvl = 3'd3;
    ae_lvl = 3'd1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'(200 + i), 1'b0, 1'b0);
    check("af_at_3", 32'(sr_almost_full), 32'h1);
    af_lvl = 3'd4;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    check("af_relaxed", 32'(sr_almost_full), 32'h0);

    $display("[TB] high-water mark and clear");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'(300 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd303, 1'b0, 1'b0);
    check("hwm", 32'(sr_max_fill_level), 32'd3);
    applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b1);
    check("clear_max", 32'(sr_max_fill_level), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] async reset mid-stream");
    applyStimulus(1'b1, 32'd400, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd401, 1'b0, 1'b0);
    ing_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    checkOutput();
    check("areset_egr_data", egr_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'hA5, 1'b0, 1'b0);
    check("post_reset_data", egr_data, 32'hA5);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/synchronous_fifo_fwft.md
Name: synchronous_fifo_fwft

Overview:
- Parametrised synchronous FIFO with first-word-fall-through (FWFT) egress and valid/ready handshakes on both sides.
- Adds programmable almost-full/almost-empty thresholds, a synchronous flush and a sticky high-water mark.
- Storage is a register array with combinational read, followed by one output register (egr_data).
- Used as the general-purpose buffering element between streaming blocks.

Parameters:
- DATA_WIDTH_P, 32, width of each stored word.
- ADDRESS_WIDTH_P, 4, log2 of capacity; total capacity CAP = 2^ADDRESS_WIDTH_P words, counting the output register.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous flush, active-high.
- ing_valid  input  1  ingress word offered.
- ing_ready  output  1  FIFO can accept a word.
- ing_data  input  DATA_WIDTH_P  ingress word.
- egr_valid  output  1  egr_data holds the oldest word.
- egr_ready  input  1  consumer takes the word.
- egr_data  output  DATA_WIDTH_P  head-of-queue word (registered).
- cr_almost_full_level  input  ADDRESS_WIDTH_P+1  almost-full threshold.
- cr_almost_empty_level  input  ADDRESS_WIDTH_P+1  almost-empty threshold.
- sr_fill_level  output  ADDRESS_WIDTH_P+1  words held, 0..CAP.
- sr_almost_full  output  1  registered flag.
- sr_almost_empty  output  1  registered flag.
- sr_max_fill_level  output  ADDRESS_WIDTH_P+1  sticky high-water mark.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers = 0, sr_fill_level = 0, egr_valid = 0, egr_data = 0, sr_max_fill_level = 0.
  - sr_almost_full = 0, sr_almost_empty = 1.
  - Array contents are not reset.
- Handshakes: push = ing_valid && ing_ready; pop = egr_valid && egr_ready.
- ing_ready = !sr_fill_level[ADDRESS_WIDTH_P], i.e. high while fill < CAP, based on the current registered fill only.
  - When full, a push is refused even if a pop occurs in the same cycle; ing_ready rises the cycle after the pop.
- sr_fill_level next value:
  - +1 on push only; -1 on pop only; unchanged on push+pop or on neither.
  - Never wraps: it is impossible to exceed CAP or go below 0.
- Bypass: if the output register is empty (or being popped) and the array is empty, the pushed word loads egr_data directly.
  - Latency is 1 cycle: push in cycle N gives egr_valid = 1 in cycle N+1.
- Otherwise a push writes array[write_address], and write_address increments, wrapping modulo 2^ADDRESS_WIDTH_P.
- Refill: when the output register is empty or popped and the array is non-empty, egr_data <= array[read_address] and read_address increments (wrapping) in the same cycle.
  - Throughput is 1 word/cycle sustained with egr_ready held high.
- egr_data and egr_valid are held stable while egr_valid && !egr_ready.
- sr_almost_full is registered from the next fill value: (next fill >= cr_almost_full_level). It is always consistent with sr_fill_level in the same cycle.
- sr_almost_empty is registered from the next fill value: (next fill <= cr_almost_empty_level).
- Threshold changes take effect on the flags one cycle later, even with no push or pop.
- sr_max_fill_level <= max(sr_max_fill_level, next fill).
- clear (highest priority over push and pop):
  - Next cycle: pointers = 0, fill = 0, egr_valid = 0, sr_max_fill_level = 0, sr_almost_empty = 1.
  - sr_almost_full = (0 >= cr_almost_full_level).
  - A push or pop concurrent with clear is discarded; ing_ready may be high, but the word is lost by definition.
- Reset asserted mid-transfer aborts all state immediately; no partial word is ever presented afterwards.
- Thresholds outside 0..CAP are not required to be meaningful; comparisons are plain unsigned on ADDRESS_WIDTH_P+1 bits.

Test Plan:
- Single word: ADDRESS_WIDTH_P=2, push 0xA5 in cycle 0 with egr_ready=0 -> egr_valid=1 and egr_data=0xA5 in cycle 1, held; fill=1; pop in cycle 3 -> fill=0, egr_valid=0 in cycle 4.
- Fill to full: with egr_ready=0, push 4 words 1..4 -> fill=4, ing_ready=0. Push 5 plus pop in the same cycle -> 5 refused, egr_data=1 popped, fill=3, ing_ready=1 next cycle. Drain yields 2,3,4 in order.
- Streaming: push 100 incrementing words with ing_valid and egr_ready held high -> one word out per cycle after 1-cycle latency, no gaps or reorder, fill stays ≤1, pointers wrap without error.
- Thresholds: almost_full_level=3, almost_empty_level=1; push 3 words -> almost_empty drops in the cycle fill becomes 2, almost_full rises in the cycle fill becomes 3. Set almost_full_level=4 -> almost_full=0 next cycle.
- High-water mark and clear: push 3, pop 2, push 1 -> sr_max_fill_level=3. Assert clear together with a push -> next cycle fill=0, egr_valid=0, max=0, and the pushed word never appears.
- Async reset mid-stream: assert rst_n low between clock edges with fill=2 -> outputs reach reset values immediately. After release, first push behaves as in the single-word case.
